// File: rtl/pma_region_lookup.sv
// pma_region_lookup: physical-address attribute oracle that scans the PMA rule tables
// RulesPerCycle rules per table per cycle and answers over a valid/ready handshake.
package config_pkg;
  localparam int unsigned NrMaxRules = 16;
  typedef struct packed {
    int unsigned NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
    int unsigned NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
    int unsigned NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0] CachedRegionLength;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module pma_region_lookup #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned RulesPerCycle = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_addr_o,
  output logic        resp_nonidem_o,
  output logic        resp_exec_o,
  output logic        resp_cached_o
);
  localparam int unsigned KW = $clog2(config_pkg::NrMaxRules);
  localparam int unsigned IdxW = KW + 1;
  localparam int unsigned NNi = CVA6Cfg.NrNonIdempotentRules;
  localparam int unsigned NEx = CVA6Cfg.NrExecuteRegionRules;
  localparam int unsigned NCa = CVA6Cfg.NrCachedRegionRules;
  localparam int unsigned NNiEx = NNi > NEx ? NNi : NEx;
  localparam int unsigned NMax = NNiEx > NCa ? NNiEx : NCa;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;
  state_e state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [IdxW-1:0] idx_q, idx_d, k;
  logic nonidem_q, nonidem_d, exec_q, exec_d, cached_q, cached_d;
  logic ni_hit, ex_hit, ca_hit, last;

  // 65-bit upper bound so a region ending exactly at 2^64 does not wrap
  function automatic logic in_region(input logic [63:0] a, input logic [63:0] b, input logic [63:0] l);
    return a >= b && {1'b0, a} < {1'b0, b} + {1'b0, l};
  endfunction

  always_comb begin
    ni_hit = 1'b0;
    ex_hit = NEx == 0;
    ca_hit = 1'b0;
    k = '0;
    for (int j = 0; j < int'(RulesPerCycle); j++) begin
      k = idx_q + IdxW'(j);
      ni_hit = ni_hit | (k < IdxW'(NNi) && in_region(addr_q, CVA6Cfg.NonIdempotentAddrBase[k[KW-1:0]], CVA6Cfg.NonIdempotentLength[k[KW-1:0]]));
      ex_hit = ex_hit | (k < IdxW'(NEx) && in_region(addr_q, CVA6Cfg.ExecuteRegionAddrBase[k[KW-1:0]], CVA6Cfg.ExecuteRegionLength[k[KW-1:0]]));
      ca_hit = ca_hit | (k < IdxW'(NCa) && in_region(addr_q, CVA6Cfg.CachedRegionAddrBase[k[KW-1:0]], CVA6Cfg.CachedRegionLength[k[KW-1:0]]));
    end
  end

  assign last = idx_q + IdxW'(RulesPerCycle) >= IdxW'(NMax);

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    idx_d = idx_q;
    nonidem_d = nonidem_q;
    exec_d = exec_q;
    cached_d = cached_q;
    if (flush_i) state_d = IDLE;
    else if (state_q == IDLE && req_valid_i) begin
      state_d = SCAN;
      addr_d = req_addr_i;
      idx_d = '0;
      nonidem_d = 1'b0;
      exec_d = 1'b0;
      cached_d = 1'b0;
    end else if (state_q == SCAN) begin
      nonidem_d = nonidem_q | ni_hit;
      exec_d = exec_q | ex_hit;
      cached_d = cached_q | ca_hit;
      idx_d = idx_q + IdxW'(RulesPerCycle);
      state_d = last ? RESP : SCAN;
    end else if (state_q == RESP && resp_ready_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q <= '0;
      idx_q <= '0;
      nonidem_q <= 1'b0;
      exec_q <= 1'b0;
      cached_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      idx_q <= idx_d;
      nonidem_q <= nonidem_d;
      exec_q <= exec_d;
      cached_q <= cached_d;
    end
  end

  assign req_ready_o = state_q == IDLE;
  assign resp_valid_o = state_q == RESP;
  assign resp_addr_o = addr_q;
  assign resp_nonidem_o = nonidem_q;
  assign resp_exec_o = exec_q;
  assign resp_cached_o = cached_q;
endmodule

// File: tb/tb_pma_region_lookup.sv
// tb_pma_region_lookup: three lookup instances (test-plan rules, empty tables, wrap/multi-rule)
// driven by directed and random queries; a scoreboard monitor checks every presented response.
module tb_pma_region_lookup;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req_valid, resp_ready, flush;
  logic [63:0] req_addr [3];
  wire [2:0] req_ready, resp_valid, r_ni, r_ex, r_ca;
  wire [63:0] resp_addr [3];
  int cyc = 0;
  int passed = 0;
  int total = 0;
  typedef struct {
    int inst;
    logic [63:0] addr;
    logic ni, ex, ca;
    int due;
  } item_t;
  item_t sb[$];
  logic [2:0] prev_v = '0;

  function automatic config_pkg::cva6_cfg_t mk_cfg(input int k);
    config_pkg::cva6_cfg_t c;
    c = '0;
    if (k == 0) begin
      c.NrNonIdempotentRules = 1;
      c.NonIdempotentLength[0] = 64'h1000_0000;
      c.NrExecuteRegionRules = 2;
      c.ExecuteRegionAddrBase[0] = 64'h1_0000;
      c.ExecuteRegionLength[0] = 64'h1_0000;
      c.ExecuteRegionAddrBase[1] = 64'h8000_0000;
      c.ExecuteRegionLength[1] = 64'h4000_0000;
      c.ExecuteRegionLength[2] = '1;
      c.NrCachedRegionRules = 1;
      c.CachedRegionAddrBase[0] = 64'h8000_0000;
      c.CachedRegionLength[0] = 64'h4000_0000;
    end else if (k == 1) begin
      c.NonIdempotentLength[0] = '1;
      c.ExecuteRegionLength[0] = '1;
      c.CachedRegionLength[0] = '1;
    end else begin
      c.NrNonIdempotentRules = 5;
      c.NonIdempotentAddrBase[0] = 64'h1000;
      c.NonIdempotentLength[0] = 64'h1000;
      c.NonIdempotentAddrBase[1] = 64'h4000_0000;
      c.NonIdempotentLength[1] = 64'h100;
      c.NonIdempotentAddrBase[2] = 64'hFFFF_FFFF_FFFF_F000;
      c.NonIdempotentLength[2] = 64'h1000;
      c.NonIdempotentAddrBase[3] = 64'h10_0000_0000;
      c.NonIdempotentLength[3] = 64'h1_0000_0000;
      c.NonIdempotentAddrBase[4] = 64'h2000;
      c.NonIdempotentLength[4] = 64'h10;
      c.NrExecuteRegionRules = 3;
      c.ExecuteRegionAddrBase[0] = 64'hFFFF_FFFF_FFFF_F000;
      c.ExecuteRegionLength[0] = 64'h1000;
      c.ExecuteRegionLength[1] = 64'h100;
      c.ExecuteRegionAddrBase[2] = 64'h8000;
      c.ExecuteRegionLength[3] = '1;
      c.NrCachedRegionRules = 1;
      c.CachedRegionAddrBase[0] = 64'hFFFF_FFFF_FFFF_FF00;
      c.CachedRegionLength[0] = 64'h100;
      c.CachedRegionLength[1] = '1;
    end
    return c;
  endfunction

  function automatic int rpc(input int i);
    return i == 0 ? 1 : i == 1 ? 4 : 2;
  endfunction

  function automatic int lat(input int i);
    config_pkg::cva6_cfg_t c = mk_cfg(i);
    int n = int'(c.NrNonIdempotentRules);
    if (int'(c.NrExecuteRegionRules) > n) n = int'(c.NrExecuteRegionRules);
    if (int'(c.NrCachedRegionRules) > n) n = int'(c.NrCachedRegionRules);
    return n == 0 ? 1 : (n + rpc(i) - 1) / rpc(i);
  endfunction

  function automatic logic inside_rule(input logic [63:0] a, input logic [63:0] b, input logic [63:0] l);
    return a >= b && (a - b) < l;
  endfunction

  function automatic void model(input int i, input logic [63:0] a, output logic ni, output logic ex, output logic ca);
    config_pkg::cva6_cfg_t c = mk_cfg(i);
    ni = 1'b0;
    ca = 1'b0;
    ex = c.NrExecuteRegionRules == 0;
    for (int r = 0; r < int'(c.NrNonIdempotentRules); r++) ni |= inside_rule(a, c.NonIdempotentAddrBase[r], c.NonIdempotentLength[r]);
    for (int r = 0; r < int'(c.NrExecuteRegionRules); r++) ex |= inside_rule(a, c.ExecuteRegionAddrBase[r], c.ExecuteRegionLength[r]);
    for (int r = 0; r < int'(c.NrCachedRegionRules); r++) ca |= inside_rule(a, c.CachedRegionAddrBase[r], c.CachedRegionLength[r]);
  endfunction

  function automatic logic [63:0] rand_addr(input int i);
    config_pkg::cva6_cfg_t c = mk_cfg(i);
    int r = int'($urandom_range(0, 15));
    int t = int'($urandom_range(0, 2));
    logic [63:0] b, l;
    b = t == 0 ? c.NonIdempotentAddrBase[r] : t == 1 ? c.ExecuteRegionAddrBase[r] : c.CachedRegionAddrBase[r];
    l = t == 0 ? c.NonIdempotentLength[r] : t == 1 ? c.ExecuteRegionLength[r] : c.CachedRegionLength[r];
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom};
      1: return {32'h0, $urandom};
      2: return b + 64'($urandom_range(0, 2)) - 64'd1;
      default: return b + l - 64'($urandom_range(0, 2));
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pma_region_lookup #(.CVA6Cfg(mk_cfg(g)), .RulesPerCycle(rpc(g))) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[g]),
      .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]), .req_addr_i(req_addr[g]),
      .resp_valid_o(resp_valid[g]), .resp_ready_i(resp_ready[g]), .resp_addr_o(resp_addr[g]),
      .resp_nonidem_o(r_ni[g]), .resp_exec_o(r_ex[g]), .resp_cached_o(r_ca[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && resp_valid[i]) begin
        if (sb.size() == 0 || sb[0].inst != i) begin
          total++;
          $display("FAIL unexpected_resp inst%0d: got addr %h expected no response", i, resp_addr[i]);
        end else begin
          check("resp_addr", resp_addr[i], sb[0].addr);
          check("nonidem", 64'(r_ni[i]), 64'(sb[0].ni));
          check("exec", 64'(r_ex[i]), 64'(sb[0].ex));
          check("cached", 64'(r_ca[i]), 64'(sb[0].ca));
          check("req_ready_busy", 64'(req_ready[i]), 64'd0);
          if (!prev_v[i]) check("latency_cycle", 64'(cyc), 64'(sb[0].due));
          if (resp_ready[i]) void'(sb.pop_front());
        end
      end
    end
    prev_v = resp_valid;
  end

  task automatic push_exp(input int i, input logic [63:0] a);
    item_t e;
    e.inst = i;
    e.addr = a;
    model(i, a, e.ni, e.ex, e.ca);
    e.due = cyc + 1 + lat(i);
    sb.push_back(e);
  endtask

  task automatic issue(input int i, input logic [63:0] a, input int hold);
    int n;
    check("req_ready_idle", 64'(req_ready[i]), 64'd1);
    push_exp(i, a);
    req_valid[i] = 1'b1;
    req_addr[i] = a;
    resp_ready[i] = hold == 0;
    @(posedge clk); #1;
    req_addr[i] = {$urandom, $urandom};
    req_valid[i] = hold > 0;
    n = 0;
    while (!resp_valid[i] && n < 40) begin @(posedge clk); #1; n++; end
    repeat (hold) begin @(posedge clk); #1; end
    req_valid[i] = 1'b0;
    resp_ready[i] = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL timeout inst%0d: got no response for addr %h expected one", i, a);
      sb.delete();
    end
    resp_ready[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string name);
    for (int i = 0; i < 3; i++) begin
      check({name, "_ready"}, 64'(req_ready[i]), 64'd1);
      check({name, "_valid"}, 64'(resp_valid[i]), 64'd0);
      check({name, "_addr"}, resp_addr[i], 64'd0);
      check({name, "_flags"}, 64'({r_ni[i], r_ex[i], r_ca[i]}), 64'd0);
    end
  endtask

  initial begin
    int n;
    req_valid = '0;
    resp_ready = '0;
    flush = '0;
    for (int i = 0; i < 3; i++) req_addr[i] = '0;
    repeat (2) @(posedge clk); #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 64'h8000_1000, 5);
    issue(0, 64'h2000, 0);
    issue(0, 64'h1_FFFF, 1);
    issue(0, 64'h2_0000, 0);
    req_valid[0] = 1'b1;
    req_addr[0] = 64'h8000_0000;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    check("ready_after_scan_flush", 64'(req_ready[0]), 64'd1);
    issue(0, 64'hBFFF_FFFF, 0);
    req_valid[0] = 1'b1;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    flush[0] = 1'b0;
    check("ready_after_idle_flush", 64'(req_ready[0]), 64'd1);
    repeat (4) @(posedge clk); #1;
    issue(1, 64'h0, 0);
    issue(1, 64'hDEAD_BEEF_0000_1234, 2);
    issue(2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    issue(2, 64'h2008, 1);
    push_exp(2, 64'h1800);
    req_valid[2] = 1'b1;
    req_addr[2] = 64'h1800;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    n = 0;
    while (!resp_valid[2] && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    flush[2] = 1'b1;
    @(posedge clk); #1;
    flush[2] = 1'b0;
    check("valid_after_resp_flush", 64'(resp_valid[2]), 64'd0);
    check("queue_before_drop", 64'(sb.size()), 64'd1);
    sb.delete();
    repeat (3) @(posedge clk); #1;
    req_valid[2] = 1'b1;
    req_addr[2] = 64'h1000;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      for (int t = 0; t < 25; t++) issue(i, rand_addr(i), int'($urandom_range(0, 2)));
    repeat (5) @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end
endmodule

// File: doc/pma_region_lookup.md
Name: pma_region_lookup

Overview:
- Sequential responder that answers physical-address attribute queries against the PMA rule tables in the core configuration (non-idempotent, execute and cached regions).
- The configuration struct holds the rules; this block reads them at run time and returns the region flags through a valid/ready request/response handshake.
- It scans a bounded number of rules per cycle so large rule sets do not create one long combinational compare path.
- Sits beside the LSU/frontend as a shared attribute oracle.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration. Supplies NrNonIdempotentRules, NrExecuteRegionRules and NrCachedRegionRules, plus the base and length arrays for each table.
- RulesPerCycle, 4, rules evaluated per table per scan cycle. Must be 1..NrMaxRules and a power of two.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort the current lookup; no response is produced
- req_valid_i  in  1  query valid
- req_ready_o  out  1  block can accept a query
- req_addr_i  in  64  physical address to classify
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts the result
- resp_addr_o  out  64  address of the query being answered
- resp_nonidem_o  out  1  address lies in a non-idempotent region
- resp_exec_o  out  1  address lies in an executable region
- resp_cached_o  out  1  address lies in a cacheable region

Behaviour:
- One clock. Reset is asynchronous and active-low: clk_i, rst_ni.
- Reset values: FSM=IDLE, req_ready_o=1, resp_valid_o=0, resp_addr_o=0, all flags=0, scan index=0.
- FSM states and transitions:
  - IDLE: req_ready_o=1. When req_valid_i&&req_ready_o, latch the address, clear the accumulators (exec accumulator also 0), set idx=0, go to SCAN.
  - SCAN: req_ready_o=0. Each cycle, evaluate rules k = idx .. idx+RulesPerCycle-1 for every table. A rule counts only if k < that table's rule count; out-of-range rules contribute 0.
  - Hit test per rule: addr >= base && {1'b0,addr} < 65'(base)+len, in 65-bit arithmetic so base+len cannot wrap. A region ending exactly at 2^64 is therefore valid.
  - OR each hit into its table's accumulator, then idx += RulesPerCycle.
  - Leave SCAN after the cycle in which idx+RulesPerCycle >= NMAX, where NMAX = max of the three rule counts. Scan cycles S = max(1, ceil(NMAX/RulesPerCycle)).
  - RESP: resp_valid_o=1 with stable outputs until resp_ready_i. On handshake go to IDLE, drop resp_valid_o, raise req_ready_o. There is no same-cycle accept of a new query; the next query is taken one cycle later.
- Exec rule: if NrExecuteRegionRules==0, resp_exec_o=1 regardless of address (everything executable). Otherwise it is the accumulated OR.
- Latency: query accepted at edge N; resp_valid_o rises after edge N+S. Minimum 1 scan cycle plus response, even with zero rules.
- flush_i in SCAN or RESP: return to IDLE the next edge with resp_valid_o=0 and the result discarded. flush_i in IDLE: accepted query is dropped (FSM stays IDLE). Flush takes priority over all other events in the same cycle.
- Changes to req_addr_i after acceptance have no effect.
- Reset mid-scan: immediate return to the reset values; no response is ever produced for the interrupted query.

Test Plan:
Bench config: RulesPerCycle=1.
- NonIdem: {base 0x0, len 0x1000_0000}.
- Exec: {0x1_0000/0x1_0000, 0x8000_0000/0x4000_0000}.
- Cached: {0x8000_0000/0x4000_0000}.
- NMAX=2, so S=2.

Scenarios:
- Query 0x8000_1000 accepted at edge 0 -> resp_valid_o at edge 2; nonidem=0, exec=1, cached=1; req_ready_o=0 during edges 1-2.
- Query 0x0000_2000 -> nonidem=1, exec=0, cached=0. Query 0x1_FFFF -> exec=1; 0x2_0000 -> exec=0 (upper bound exclusive).
- Hold resp_ready_i=0 for 5 cycles -> resp_valid_o and flags stable for all 5; req_ready_o=0; the query issued during the hold is not accepted.
- Assert flush_i in the first SCAN cycle -> no resp_valid_o; req_ready_o=1 next cycle; next query 0xBFFF_FFFF answers cached=1, exec=1.
- Config with NrExecuteRegionRules=0 and all counts 0 -> any address gives exec=1, nonidem=0, cached=0, resp_valid_o 1 cycle after accept.
- Rule base 0xFFFF_FFFF_FFFF_F000, len 0x1000 -> address 0xFFFF_FFFF_FFFF_FFFF hits (no 64-bit wrap).
- Deassert rst_ni mid-SCAN -> outputs go to reset values asynchronously; no response is produced.
